// File: rtl/redun_carry_normalizer.sv
// Redundant-to-canonical carry normalizer.
// Captures one block of redundant digits (WORD_LEN value bits plus carry
// bits each), then walks it from the least-significant digit upward,
// folding the carry into each digit and streaming canonical WORD_LEN-bit
// words out over a valid/ready handshake.
module redun_carry_normalizer #(
  parameter int NUM_ELEMENTS = 66,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DSP_BIT_LEN-1:0] i_dat [NUM_ELEMENTS],
  input  logic                   i_val,
  output logic                   o_rdy,
  output logic [WORD_LEN-1:0]    o_dat,
  output logic [1:0]             o_carry,
  output logic                   o_last,
  output logic                   o_val,
  input  logic                   i_rdy
);

  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t                 state;
  logic [DSP_BIT_LEN-1:0] dig_buf [NUM_ELEMENTS];
  logic [IDX_W-1:0]       idx;
  logic [1:0]             carry;

  logic [DSP_BIT_LEN:0]   sum;
  logic [WORD_LEN-1:0]    word;
  logic [1:0]             carry_nxt;
  logic                   is_last;

  // One extra bit of headroom: an all-ones digit plus the largest carry (2)
  // still fits, so the carry out of any digit never exceeds 2.
  function automatic logic [DSP_BIT_LEN:0] digit_add(
    input logic [DSP_BIT_LEN-1:0] d,
    input logic [1:0]             c
  );
    return {1'b0, d} + {{(DSP_BIT_LEN - 1){1'b0}}, c};
  endfunction

  // Fold the running carry into the current digit and split word/carry.
  always_comb begin
    sum       = digit_add(dig_buf[idx], carry);
    word      = sum[WORD_LEN-1:0];
    carry_nxt = sum[WORD_LEN +: 2];
    is_last   = (idx == LAST_IDX);
  end

  // Digit buffer: data only, loaded when a transaction is accepted.
  always_ff @(posedge i_clk) begin
    if (state == IDLE && i_val) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        dig_buf[i] <= i_dat[i];
      end
    end
  end

  // Control FSM with registered handshake and output word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_rdy   <= 1'b1;
      o_val   <= 1'b0;
      o_last  <= 1'b0;
      o_carry <= 2'd0;
      o_dat   <= '0;
      idx     <= '0;
      carry   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_val) begin
            idx   <= '0;
            carry <= 2'd0;
            o_rdy <= 1'b0;
            state <= LOAD;
          end
        end
        LOAD: begin
          o_dat   <= word;
          o_val   <= 1'b1;
          o_last  <= is_last;
          o_carry <= is_last ? carry_nxt : 2'd0;
          carry   <= carry_nxt;
          idx     <= idx + 1'b1;
          state   <= RUN;
        end
        RUN: begin
          // Output register holds while the consumer stalls.
          if (i_rdy) begin
            if (o_last) begin
              o_val   <= 1'b0;
              o_last  <= 1'b0;
              o_carry <= 2'd0;
              o_rdy   <= 1'b1;
              state   <= IDLE;
            end else begin
              o_dat   <= word;
              o_last  <= is_last;
              o_carry <= is_last ? carry_nxt : 2'd0;
              carry   <= carry_nxt;
              idx     <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          o_rdy <= 1'b1;
          o_val <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/redun_carry_normalizer.md
Name: redun_carry_normalizer

Overview:
- Sits directly downstream of the multi-mode multiplier in the redundant Montgomery datapath.
- Captures one NUM_ELEMENTS-digit redundant result per transaction. Each digit is DSP_BIT_LEN bits: WORD_LEN value bits plus carry bits.
- Serially propagates carries from least- to most-significant digit and streams canonical WORD_LEN-bit words out under valid/ready backpressure.
- Typical uses: final reduction check and host readback of the squaring result.

Parameters:
- NUM_ELEMENTS, 66, number of redundant input digits (multiplier output width, 2x its element count).
- DSP_BIT_LEN, 17, width of each redundant input digit.
- WORD_LEN, 16, width of each canonical output word; must be < DSP_BIT_LEN.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_dat  in  DSP_BIT_LEN x NUM_ELEMENTS (unpacked array)  redundant digits, index 0 least significant.
- i_val  in  1  input digits valid.
- o_rdy  out  1  block can accept a new input.
- o_dat  out  WORD_LEN  canonical output word.
- o_carry  out  2  final carry-out; meaningful only when o_last=1, otherwise 0.
- o_last  out  1  marks the final word (index NUM_ELEMENTS-1).
- o_val  out  1  o_dat/o_last/o_carry valid.
- i_rdy  in  1  downstream accepts the current output word.

Behaviour:
- Reset (i_rst_n=0 at a clock edge): state=IDLE, o_rdy=1, o_val=0, o_last=0, o_carry=0, o_dat=0, index=0, carry=0.
- Reset mid-operation aborts the transaction immediately; no further words are emitted and the buffer contents are don't-care.
- Internal width rules:
  - sum = buf[idx] + carry, DSP_BIT_LEN+1 bits.
  - word = sum[WORD_LEN-1:0].
  - next carry = sum >> WORD_LEN, stored in 2 bits. Bound: max digit 2^17-1 plus carry 2 gives carry <= 2, so no overflow.
- FSM IDLE:
  - o_rdy=1, o_val=0.
  - On i_val & o_rdy: capture all i_dat into the buffer, idx=0, carry=0, o_rdy<=0, go LOAD.
- FSM LOAD (1 cycle):
  - Register word for idx=0 into o_dat, o_val<=1, update carry, idx<=1, go RUN.
  - o_last<=1 if NUM_ELEMENTS==1.
- FSM RUN: output register holds while o_val & ~i_rdy; o_dat, o_last and o_carry are stable under backpressure. On o_val & i_rdy:
  - If the current word is not last: load the next word from buf[idx], update carry, idx++.
  - When loading word NUM_ELEMENTS-1: set o_last=1 and o_carry = carry-out from that final digit.
  - If the current word is last: o_val<=0, o_last<=0, o_carry<=0, o_rdy<=1, go IDLE.
- Latency: input accepted at edge T, first word valid after edge T+1. With i_rdy held high, word k is valid after edge T+1+k, the last after edge T+NUM_ELEMENTS, and o_rdy=1 after edge T+NUM_ELEMENTS+1.
- Throughput: one word per cycle when not backpressured; a new input can be accepted the cycle after IDLE is re-entered.
- Simultaneous i_val while busy: ignored; o_rdy=0, and the upstream must hold its data.
- i_val asserted in the same cycle the last word is accepted: not captured; it is captured in the following cycle.
- Input digit bits above WORD_LEN are fully honoured. All-ones digits (2^DSP_BIT_LEN-1) must propagate correctly.
- No combinational path from i_val to o_val or from i_rdy to o_rdy. All outputs are registered.

Test Plan:
- NUM_ELEMENTS=4, digits {0x0001,0x0002,0x0003,0x0004} (idx0 first), i_rdy=1 -> words 0x0001,0x0002,0x0003,0x0004 on 4 consecutive cycles; o_last on the 4th; o_carry=0; o_rdy high one cycle after.
- NUM_ELEMENTS=4, all digits 0x1FFFF -> words 0xFFFF, 0xFFFF+1 wraps to 0x0000 with carry 2, then 0x0001, 0x0001; final o_carry=2.
  - Bench must check against a golden big-integer sum of digit[i]*2^(16*i).
- Digits {0x10000,0,0,0} -> words 0x0000,0x0001,0x0000,0x0000; o_carry=0.
- Backpressure: i_rdy toggles 1,0,0,1,... -> each word held stable while i_rdy=0; no word lost or duplicated; order unchanged.
- i_val held high continuously with two distinct input sets -> the second set is captured only after the first transaction's o_last handshake; o_rdy=0 throughout the first.
- Assert i_rst_n=0 for one cycle after word 1 of a transaction -> o_val=0, o_rdy=1 next cycle; a new transaction then produces correct words starting from index 0 with carry 0.
